// File: rtl/cfu_pkg.sv
// Shared types and encodings for the fetch/decode/sequencing unit.
// Instruction layout: [17:14] opcode, [13:9] op1, [8:4] op2, [3] imControl, [2:0] kind.
package cfu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] K_ALU   = 3'd0;
   localparam logic [2:0] K_LOADI = 3'd1;
   localparam logic [2:0] K_LOAD  = 3'd2;
   localparam logic [2:0] K_STORE = 3'd3;
   localparam logic [2:0] K_JUMP  = 3'd4;
   localparam logic [2:0] K_HALT  = 3'd5;

   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_JUMP = 2'd1;
   localparam logic [1:0] PC_HOLD = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_IMM = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;

   localparam int IR_W     = 18;
   localparam int OPC_LSB  = 14;
   localparam int OP1_LSB  = 9;
   localparam int OP2_LSB  = 4;
   localparam int IMC_BIT  = 3;
   localparam int KIND_LSB = 0;

endpackage

// File: rtl/cfu_decoder.sv
// Combinational instruction decoder: splits the IR into operand fields and
// classifies the instruction kind for the sequencer.
import cfu_pkg::*;

module cfu_decoder (
   input  logic [IR_W-1:0] ir,
   output logic [3:0]      opcode,
   output logic [4:0]      op1,
   output logic [4:0]      op2,
   output logic            imc,
   output logic [2:0]      kind,
   output logic            needs_mem,
   output logic            writes_reg,
   output logic            is_jump,
   output logic [1:0]      wcode
);

   assign opcode = ir[OPC_LSB +: 4];
   assign op1    = ir[OP1_LSB +: 5];
   assign op2    = ir[OP2_LSB +: 5];
   assign imc    = ir[IMC_BIT];
   assign kind   = ir[KIND_LSB +: 3];

   // Kinds with no register write (STORE, JUMP, HALT, illegal) leave wcode at ALU.
   always_comb begin
      needs_mem  = 1'b0;
      writes_reg = 1'b0;
      is_jump    = 1'b0;
      wcode      = WB_ALU;
      case (kind)
         K_ALU:   writes_reg = 1'b1;
         K_LOADI: begin writes_reg = 1'b1; wcode = WB_IMM; end
         K_LOAD:  begin writes_reg = 1'b1; needs_mem = 1'b1; wcode = WB_MEM; end
         K_STORE: needs_mem = 1'b1;
         K_JUMP:  is_jump = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_fetch_decode.sv
// Multi-cycle fetch/decode/sequencer driving the datapath control inputs.
// Optional CFU_ILLEGAL_TRAP_EN: illegal kinds halt and set the sticky illegal flag.
import cfu_pkg::*;

module ctrl_fetch_decode #(
   parameter int IADDR_W = 10,
   parameter int IWORD_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        PC,
   output logic [IADDR_W-1:0] imem_addr,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [IWORD_W-1:0] imem_data,
   output logic [3:0]         opcode,
   output logic [4:0]         op1,
   output logic [4:0]         op2,
   output logic               imControl,
   output logic               regenable,
   output logic               ramenable,
   output logic [1:0]         pcControl,
   output logic [1:0]         writecode,
   output logic               halted,
   output logic               illegal,
   output logic [2:0]         dbg_state
);

   state_t          state;
   logic [IR_W-1:0] ir;

   logic [3:0] d_opcode;
   logic [4:0] d_op1, d_op2;
   logic       d_imc, d_needs_mem, d_writes_reg, d_is_jump;
   logic [2:0] d_kind;
   logic [1:0] d_wcode;

   cfu_decoder u_dec (
      .ir         (ir),
      .opcode     (d_opcode),
      .op1        (d_op1),
      .op2        (d_op2),
      .imc        (d_imc),
      .kind       (d_kind),
      .needs_mem  (d_needs_mem),
      .writes_reg (d_writes_reg),
      .is_jump    (d_is_jump),
      .wcode      (d_wcode)
   );

   // Gated by reset so the fetch port reads idle while reset is held.
   assign imem_req  = (state == S_FETCH) && !reset;
   assign imem_addr = imem_req ? PC[IADDR_W-1:0] : '0;
   assign dbg_state = state;

   logic unused_bits;
   assign unused_bits = ^{PC[31:IADDR_W], imem_data[IWORD_W-1:IR_W]};

   // Pulses default low and pcControl defaults to hold; only the edge entering
   // MEM or WB raises them, so each lasts exactly one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_FETCH;
         ir        <= '0;
         opcode    <= '0;
         op1       <= '0;
         op2       <= '0;
         imControl <= 1'b0;
         writecode <= WB_ALU;
         regenable <= 1'b0;
         ramenable <= 1'b0;
         pcControl <= PC_HOLD;
         halted    <= 1'b0;
`ifdef CFU_ILLEGAL_TRAP_EN
         illegal   <= 1'b0;
`endif
      end else begin
         regenable <= 1'b0;
         ramenable <= 1'b0;
         pcControl <= PC_HOLD;
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_data[IR_W-1:0];
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               opcode    <= d_opcode;
               op1       <= d_op1;
               op2       <= d_op2;
               imControl <= d_imc;
               writecode <= d_wcode;
               if (d_kind == K_HALT) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
`ifdef CFU_ILLEGAL_TRAP_EN
               end else if (d_kind > K_HALT) begin
                  state   <= S_HALT;
                  halted  <= 1'b1;
                  illegal <= 1'b1;
`endif
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (d_needs_mem) begin
                  state     <= S_MEM;
                  ramenable <= 1'b1;
               end else begin
                  state     <= S_WB;
                  regenable <= d_writes_reg;
                  pcControl <= d_is_jump ? PC_JUMP : PC_INC;
               end
            end
            S_MEM: begin
               state     <= S_WB;
               regenable <= d_writes_reg;
               pcControl <= PC_INC;
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifndef CFU_ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

endmodule
